cop_ise_seq: RTL and testbench

Sequential, parametrised co-processor interface for the Xoodyak ISE. It sits between the core's co-processor port and the bit-manipulation datapath. It decodes `roli`, `roliw` and `andn` for XLEN 32 or 64, registers every result, and holds it under core back-pressure. An optional area-saving serial rotator makes rotations multi-cycle, with `cop_wait` signalling busy.

---
 rtl/cop_ise_pkg.sv | 39 +++
 rtl/xoodyak_rot_unit.sv | 24 ++
 rtl/cop_ise_seq.sv | 147 ++++++++++++++
 tb/tb_cop_ise_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop_ise_pkg.sv
// Shared opcodes, op/state encodings and instruction decode for the Xoodyak ISE co-processor.
// The serial rotator is enabled by defining XOODYAK_ISE_SERIAL_ROT_EN.
package cop_ise_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ROLI  = 2'd1,
    OP_ROLIW = 2'd2,
    OP_ANDN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // roliw exists only on RV64, so it decodes to OP_NONE when xlen is 32.
  function automatic op_e decode_op(input logic [31:0] insn, input int unsigned xlen);
    logic [6:0] funct;
    funct     = insn[31:25];
    decode_op = OP_NONE;
    if (insn[6:0] == CUSTOM_0) begin
      if (funct[6:5] == 2'b00) begin
        decode_op = OP_ROLI;
      end else if (funct[6:5] == 2'b01 && xlen == 64) begin
        decode_op = OP_ROLIW;
      end
    end else if (insn[6:0] == CUSTOM_1 && funct == 7'b0000000) begin
      decode_op = OP_ANDN;
    end
  endfunction

endpackage

// File: rtl/xoodyak_rot_unit.sv
// Combinational left rotator by 0..31 over XLEN bits, or over the low 32 bits in w32 mode.
// In w32 mode the upper result bits are zero; sign-extension happens at write-back.
module xoodyak_rot_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [4:0]      amt_i,
  input  logic            w32_i,
  output logic [XLEN-1:0] rot_o
);

  logic [XLEN-1:0] rot_full;
  logic [31:0]     data_lo;
  logic [31:0]     rot_lo;

  always_comb begin
    data_lo  = data_i[31:0];
    // A right shift by the full width yields zero, so amt 0 needs no special case.
    rot_full = (data_i << amt_i) | (data_i >> (XLEN - 32'(amt_i)));
    rot_lo   = (data_lo << amt_i) | (data_lo >> (32 - 32'(amt_i)));
    rot_o    = w32_i ? XLEN'(rot_lo) : rot_full;
  end

endmodule

// File: rtl/cop_ise_seq.sv
// Sequential Xoodyak ISE co-processor front end: decodes roli/roliw/andn, registers the result
// and holds it under back-pressure. Define XOODYAK_ISE_SERIAL_ROT_EN for the multi-cycle rotator.
module cop_ise_seq
  import cop_ise_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          ISE_V    = 1'b1,
  parameter int unsigned ROT_STEP = 4
) (
  input  logic            cop_clk,
  input  logic            cop_rst,
  input  logic            cop_valid,
  input  logic            cop_rdywr,
  output logic            cop_ready,
  output logic            cop_wait,
  output logic            cop_wr,
  input  logic [31:0]     cop_insn,
  input  logic [XLEN-1:0] cop_rs1,
  input  logic [XLEN-1:0] cop_rs2,
  output logic [XLEN-1:0] cop_rd
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("cop_ise_seq: XLEN must be 32 or 64");
  end
  if (ROT_STEP < 1 || ROT_STEP > 16 || (ROT_STEP & (ROT_STEP - 1)) != 0) begin : g_bad_step
    $error("cop_ise_seq: ROT_STEP must be a power of two from 1 to 16");
  end

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [XLEN-1:0] work_q, work_d;

  op_e             dec_op;
  logic [4:0]      dec_amt;
  logic            accept;

  logic [XLEN-1:0] rot_in;
  logic [4:0]      rot_amt;
  logic            rot_w32;
  logic [XLEN-1:0] rot_out;

  assign dec_op  = ISE_V ? decode_op(cop_insn, XLEN) : OP_NONE;
  assign dec_amt = cop_insn[29:25];
  assign accept  = cop_valid && cop_ready && (dec_op != OP_NONE);

`ifdef XOODYAK_ISE_SERIAL_ROT_EN
  localparam logic [4:0] Step = 5'(ROT_STEP);

  logic [4:0] rem_q, rem_d;
  logic [4:0] step;

  assign step    = (rem_q > Step) ? Step : rem_q;
  assign rot_in  = work_q;
  assign rot_amt = step;
  assign rot_w32 = (op_q == OP_ROLIW);
`else
  assign rot_in  = cop_rs1;
  assign rot_amt = dec_amt;
  assign rot_w32 = (dec_op == OP_ROLIW);
`endif

  xoodyak_rot_unit #(
    .XLEN (XLEN)
  ) u_rot (
    .data_i (rot_in),
    .amt_i  (rot_amt),
    .w32_i  (rot_w32),
    .rot_o  (rot_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = dec_op;
          state_d = S_RESP;
          if (dec_op == OP_ANDN) begin
            work_d = cop_rs1 & ~cop_rs2;
          end else begin
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
            work_d = cop_rs1;
            rem_d  = dec_amt;
            if (dec_amt != 5'd0) state_d = S_EXEC;
`else
            work_d = rot_out;
`endif
          end
        end
      end
      S_EXEC: begin
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
        work_d = rot_out;
        rem_d  = rem_q - step;
        if (rem_d == 5'd0) state_d = S_RESP;
`else
        state_d = S_IDLE;
`endif
      end
      S_RESP: begin
        if (cop_rdywr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cop_clk or posedge cop_rst) begin
    if (cop_rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      work_q  <= '0;
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign cop_ready = (state_q == S_IDLE) && !cop_rst;
  assign cop_wr    = (state_q == S_RESP);
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
  assign cop_wait  = (state_q == S_EXEC);
`else
  assign cop_wait  = 1'b0;
`endif

  // roliw keeps its 32-bit rotation in the low word; widen with bit 31 only on write-back.
  always_comb begin
    cop_rd = '0;
    if (cop_wr) begin
      cop_rd = (op_q == OP_ROLIW) ? XLEN'(signed'(work_q[31:0])) : work_q;
    end
  end

endmodule

// File: tb/tb_cop_ise_seq.sv
// Randomised and directed bench for cop_ise_seq against a behavioural instruction model.
// Builds for either rotator configuration (XOODYAK_ISE_SERIAL_ROT_EN).
module tb_cop_ise_seq;

  localparam int unsigned TbStep = 4;
`ifdef XOODYAK_ISE_SERIAL_ROT_EN
  localparam bit Serial = 1'b1;
`else
  localparam bit Serial = 1'b0;
`endif
  localparam logic [6:0] OpC0 = 7'b0001011;
  localparam logic [6:0] OpC1 = 7'b0101011;
  localparam logic [6:0] OpC2 = 7'b1011011;

  logic        clk = 1'b0;
  logic        cop_rst;
  logic        cop_valid;
  logic        cop_rdywr;
  logic        cop_ready;
  logic        cop_wait;
  logic        cop_wr;
  logic [31:0] cop_insn;
  logic [63:0] cop_rs1;
  logic [63:0] cop_rs2;
  logic [63:0] cop_rd;

  logic        valid32;
  logic        ready32;
  logic        wait32;
  logic        wr32;
  logic [31:0] rd32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cop_ise_seq #(
    .XLEN     (64),
    .ISE_V    (1'b1),
    .ROT_STEP (TbStep)
  ) u_dut (
    .cop_clk   (clk),
    .cop_rst   (cop_rst),
    .cop_valid (cop_valid),
    .cop_rdywr (cop_rdywr),
    .cop_ready (cop_ready),
    .cop_wait  (cop_wait),
    .cop_wr    (cop_wr),
    .cop_insn  (cop_insn),
    .cop_rs1   (cop_rs1),
    .cop_rs2   (cop_rs2),
    .cop_rd    (cop_rd)
  );

  cop_ise_seq #(
    .XLEN     (32),
    .ISE_V    (1'b1),
    .ROT_STEP (TbStep)
  ) u_dut32 (
    .cop_clk   (clk),
    .cop_rst   (cop_rst),
    .cop_valid (valid32),
    .cop_rdywr (cop_rdywr),
    .cop_ready (ready32),
    .cop_wait  (wait32),
    .cop_wr    (wr32),
    .cop_insn  (cop_insn),
    .cop_rs1   (cop_rs1[31:0]),
    .cop_rs2   (cop_rs2[31:0]),
    .cop_rd    (rd32)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rotate left bit by bit over the low `width` bits.
  function automatic logic [63:0] ref_rotl(input logic [63:0] x, input int amt, input int width);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[(i + amt) % width] = x[i];
    return r;
  endfunction

  task automatic model(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                       output bit recog, output logic [63:0] val, output int lat);
    logic [6:0]  funct;
    logic [63:0] r;
    int          amt;
    funct = insn[31:25];
    amt   = int'(funct[4:0]);
    recog = 1'b0;
    val   = '0;
    lat   = 1;
    if (insn[6:0] == OpC0 && funct[6:5] == 2'b00) begin
      recog = 1'b1;
      val   = ref_rotl(a, amt, 64);
      if (Serial) lat = 1 + (amt + TbStep - 1) / TbStep;
    end else if (insn[6:0] == OpC0 && funct[6:5] == 2'b01) begin
      recog = 1'b1;
      r     = ref_rotl(a & 64'hFFFF_FFFF, amt, 32);
      val   = {{32{r[31]}}, r[31:0]};
      if (Serial) lat = 1 + (amt + TbStep - 1) / TbStep;
    end else if (insn[6:0] == OpC1 && funct == 7'd0) begin
      recog = 1'b1;
      val   = a & ~b;
    end
  endtask

  function automatic logic [31:0] gen_insn(input int kind, input logic [4:0] amt);
    logic [17:0] mid;
    mid = 18'($urandom);
    case (kind)
      0:       return {2'b00, amt, mid, OpC0};
      1:       return {2'b01, amt, mid, OpC0};
      2:       return {7'd0, mid, OpC1};
      3:       return {7'($urandom), mid, OpC2};
      4:       return {2'b1, 1'b0, amt[3:0], mid, OpC0};
      default: return {7'($urandom_range(1, 127)), mid, OpC1};
    endcase
  endfunction

  // Issue one instruction, follow it to write-back, and apply `hold` cycles of back-pressure.
  task automatic run_insn(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                          input int hold);
    bit          recog;
    logic [63:0] exp_val;
    int          lat;
    int          k;
    model(insn, a, b, recog, exp_val, lat);
    check_eq("ready_pre", 64'(cop_ready), 64'd1);
    cop_valid = 1'b1;
    cop_insn  = insn;
    cop_rs1   = a;
    cop_rs2   = b;
    cop_rdywr = 1'b0;
    tick();
    cop_valid = 1'b0;
    cop_insn  = $urandom;
    cop_rs1   = {$urandom, $urandom};
    cop_rs2   = {$urandom, $urandom};
    if (!recog) begin
      for (int i = 0; i < 3; i++) begin
        check_eq("ignored_wr", 64'(cop_wr), 64'd0);
        check_eq("ignored_ready", 64'(cop_ready), 64'd1);
        tick();
      end
      return;
    end
    k = 1;
    while (!cop_wr && k < 40) begin
      check_eq("busy_wait", 64'(cop_wait), 64'(Serial));
      check_eq("busy_rd_zero", cop_rd, 64'd0);
      tick();
      k++;
    end
    check_eq("wr_seen", 64'(cop_wr), 64'd1);
    check_eq("latency", 64'(k), 64'(lat));
    check_eq("result", cop_rd, exp_val);
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        cop_valid = 1'b1;
        cop_insn  = {7'd0, 18'd0, OpC1};
      end
      tick();
      check_eq("hold_wr", 64'(cop_wr), 64'd1);
      check_eq("hold_rd", cop_rd, exp_val);
      check_eq("hold_ready", 64'(cop_ready), 64'd0);
      check_eq("hold_wait", 64'(cop_wait), 64'd0);
    end
    cop_valid = 1'b0;
    cop_rdywr = 1'b1;
    tick();
    cop_rdywr = 1'b0;
    check_eq("post_wr", 64'(cop_wr), 64'd0);
    check_eq("post_ready", 64'(cop_ready), 64'd1);
    check_eq("post_rd_zero", cop_rd, 64'd0);
  endtask

  initial begin
    logic [31:0] insn;
    int          kind;
    cop_rst   = 1'b1;
    cop_valid = 1'b0;
    valid32   = 1'b0;
    cop_rdywr = 1'b0;
    cop_insn  = '0;
    cop_rs1   = '0;
    cop_rs2   = '0;
    #12;
    check_eq("rst_ready", 64'(cop_ready), 64'd0);
    check_eq("rst_wr", 64'(cop_wr), 64'd0);
    check_eq("rst_wait", 64'(cop_wait), 64'd0);
    check_eq("rst_rd", cop_rd, 64'd0);
    tick();
    cop_rst = 1'b0;
    #1;
    check_eq("rel_ready", 64'(cop_ready), 64'd1);
    tick();

    run_insn({7'd0, 18'd0, OpC1}, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 0);
    run_insn({2'b00, 5'd13, 18'd0, OpC0}, 64'h1, 64'h0, 0);
    run_insn({2'b01, 5'd1, 18'd0, OpC0}, 64'h0000000040000000, 64'h0, 0);
    run_insn({2'b00, 5'd0, 18'd0, OpC0}, 64'h8000_0000_0000_0001, 64'h0, 0);
    run_insn({7'd0, 18'd0, OpC1}, 64'h0123456789ABCDEF, 64'hFF00FF00FF00FF00, 3);

    // roliw is not an RV32 instruction.
    insn = {2'b01, 5'd1, 18'd0, OpC0};
    cop_insn = insn;
    cop_rs1  = 64'h40000000;
    check_eq("x32_ready", 64'(ready32), 64'd1);
    valid32 = 1'b1;
    tick();
    valid32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("x32_roliw_wr", 64'(wr32), 64'd0);
      check_eq("x32_roliw_rd", 64'(rd32), 64'd0);
      tick();
    end

    run_insn({7'd0, 18'h155, OpC2}, 64'hDEAD, 64'hBEEF, 0);
    run_insn({7'd0, 18'd0, OpC1}, 64'hAAAA_5555_AAAA_5555, 64'h0000_FFFF_0000_FFFF, 1);

    // Abort an in-flight rotate with an asynchronous reset pulse.
    cop_valid = 1'b1;
    cop_insn  = {2'b00, 5'd13, 18'd0, OpC0};
    cop_rs1   = 64'h1;
    tick();
    cop_valid = 1'b0;
    tick();
    #2;
    cop_rst = 1'b1;
    #1;
    check_eq("abort_wr", 64'(cop_wr), 64'd0);
    check_eq("abort_wait", 64'(cop_wait), 64'd0);
    check_eq("abort_rd", cop_rd, 64'd0);
    check_eq("abort_ready", 64'(cop_ready), 64'd0);
    tick();
    cop_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("abort_no_wr", 64'(cop_wr), 64'd0);
      check_eq("abort_idle", 64'(cop_ready), 64'd1);
    end

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 5));
      if (kind >= 3 && $urandom_range(0, 1) == 0) kind = int'($urandom_range(0, 2));
      insn = gen_insn(kind, 5'($urandom));
      run_insn(insn, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
